// File: rtl/of_ex_stage_reg.sv
// of_ex_stage_reg: OF->EX pipeline register with two-entry skid buffer, flush-to-bubble and stall counter
module of_ex_stage_reg #(
    parameter int XLEN = 32,
    parameter int CTRL_W = 24,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h6800_0000,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   instr_in,
    input  logic [XLEN-1:0]   a_in,
    input  logic [XLEN-1:0]   b_in,
    input  logic [XLEN-1:0]   op2_in,
    input  logic [XLEN-1:0]   btarget_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   instr_out,
    output logic [XLEN-1:0]   a_out,
    output logic [XLEN-1:0]   b_out,
    output logic [XLEN-1:0]   op2_out,
    output logic [XLEN-1:0]   btarget_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PW = 6 * XLEN + CTRL_W;
    localparam logic [PW-1:0] BUBBLE = {{XLEN{1'b0}}, NOP_INSTR, {(4 * XLEN + CTRL_W){1'b0}}};
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state;
    logic [PW-1:0] main_q, skid_q, in_pay;
    logic in_fire, out_fire;
    assign in_ready = reset && !flush && (state != FULL);
    assign in_fire = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign in_pay = {pc_in, instr_in, a_in, b_in, op2_in, btarget_in, ctrl_in};
    assign {pc_out, instr_out, a_out, b_out, op2_out, btarget_out, ctrl_out} = main_q;
    assign occupancy = state;
    // main_q is reloaded with the bubble whenever the stage empties, so outputs stay registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
            out_valid <= 1'b0;
            main_q <= BUBBLE;
            skid_q <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (flush) begin
                state <= EMPTY;
                out_valid <= 1'b0;
                main_q <= BUBBLE;
            end else begin
                case (state)
                    EMPTY: if (in_fire) begin
                        main_q <= in_pay;
                        state <= ONE;
                        out_valid <= 1'b1;
                    end
                    ONE: if (in_fire && out_fire) begin
                        main_q <= in_pay;
                    end else if (in_fire) begin
                        skid_q <= in_pay;
                        state <= FULL;
                    end else if (out_fire) begin
                        main_q <= BUBBLE;
                        state <= EMPTY;
                        out_valid <= 1'b0;
                    end
                    FULL: if (out_fire) begin
                        main_q <= skid_q;
                        state <= ONE;
                    end
                    default: begin
                        state <= EMPTY;
                        out_valid <= 1'b0;
                        main_q <= BUBBLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_of_ex_stage_reg.sv
// tb_of_ex_stage_reg: directed and random stimulus against a queue-based model of the stage
module tb_of_ex_stage_reg;
    localparam int XLEN = 32;
    localparam int CTRL_W = 24;
    localparam int CNT_W = 4;
    localparam int PW = 6 * XLEN + CTRL_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [PW-1:0] BUBBLE = {32'h0, 32'h6800_0000, {(4 * XLEN + CTRL_W){1'b0}}};
    logic clk = 1'b0;
    logic reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0] pc_in, instr_in, a_in, b_in, op2_in, btarget_in;
    logic [XLEN-1:0] pc_out, instr_out, a_out, b_out, op2_out, btarget_out;
    logic [CTRL_W-1:0] ctrl_in, ctrl_out;
    logic [1:0] occupancy;
    logic [CNT_W-1:0] stall_cnt;
    int errors = 0;
    int checks = 0;
    logic [PW-1:0] q[$];
    int cnt = 0;
    always #5 clk = ~clk;
    of_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NOP_INSTR(32'h6800_0000), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr_in(instr_in), .a_in(a_in), .b_in(b_in), .op2_in(op2_in),
        .btarget_in(btarget_in), .ctrl_in(ctrl_in), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instr_out(instr_out), .a_out(a_out), .b_out(b_out), .op2_out(op2_out),
        .btarget_out(btarget_out), .ctrl_out(ctrl_out), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input logic rst, input logic fl, input logic iv, input logic ordy, input logic [XLEN-1:0] pc);
        logic exp_rdy, in_fire, out_fire;
        logic [PW-1:0] pay, head;
        reset = rst;
        flush = fl;
        in_valid = iv;
        out_ready = ordy;
        pc_in = pc;
        instr_in = $urandom;
        a_in = $urandom;
        b_in = $urandom;
        op2_in = $urandom;
        btarget_in = $urandom;
        ctrl_in = CTRL_W'($urandom);
        #1;
        exp_rdy = rst && !fl && q.size() < 2;
        chk("in_ready", 256'(in_ready), 256'(exp_rdy));
        pay = {pc_in, instr_in, a_in, b_in, op2_in, btarget_in, ctrl_in};
        if (!rst) begin
            q.delete();
            cnt = 0;
        end else begin
            if (q.size() > 0 && !ordy && cnt < CNT_MAX) cnt++;
            out_fire = q.size() > 0 && ordy;
            in_fire = iv && exp_rdy;
            if (fl) q.delete();
            else begin
                if (out_fire) void'(q.pop_front());
                if (in_fire) q.push_back(pay);
            end
        end
        @(posedge clk);
        #1;
        head = q.size() > 0 ? q[0] : BUBBLE;
        chk("out_valid", 256'(out_valid), 256'(q.size() > 0));
        chk("occupancy", 256'(occupancy), 256'(q.size()));
        chk("stall_cnt", 256'(stall_cnt), 256'(cnt));
        chk("payload", 256'({pc_out, instr_out, a_out, b_out, op2_out, btarget_out, ctrl_out}), 256'(head));
        chk("ctrl_out", 256'(ctrl_out), 256'(head[CTRL_W-1:0]));
    endtask
    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h4);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 1, 32'(i * 4));
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 32'h10);
        step(1, 0, 1, 0, 32'h14);
        step(1, 0, 1, 0, 32'h18);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 32'h30);
        step(1, 0, 1, 0, 32'h34);
        step(1, 1, 1, 0, 32'h20);
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 32'h40);
        step(1, 0, 1, 0, 32'h44);
        step(0, 0, 1, 1, 32'h48);
        step(1, 0, 1, 0, 32'h50);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 32'(32'h100 + i * 4));
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
